// File: rtl/laser_clk_sched_if.sv
// Bundles the scheduler's requester side and ClockDivider control.
// The scheduler takes the slave modport; the link-layer/divider side takes master.
interface laser_clk_sched_if;
    logic [1:0] req;
    logic [7:0] div_cfg0;
    logic [7:0] div_cfg1;
    logic [1:0] gnt;
    logic       ready;
    logic       div_en;
    logic [7:0] div_value;
    logic       busy;

    modport slave (
        input  req,
        input  div_cfg0,
        input  div_cfg1,
        output gnt,
        output ready,
        output div_en,
        output div_value,
        output busy
    );

    modport master (
        output req,
        output div_cfg0,
        output div_cfg1,
        input  gnt,
        input  ready,
        input  div_en,
        input  div_value,
        input  busy
    );
endinterface

// File: rtl/laser_clk_sched.sv
// Round-robin owner of the shared ClockDivider (0 = TX framer, 1 = RX sampler) with glitch-safe
// disable/guard/load/enable sequencing. Define LASER_CLK_SCHED_STATS_EN for preempt/grant counters.
module laser_clk_sched #(
    parameter int GUARD_CYC = 4,
    parameter int MAX_HOLD  = 1024,
    parameter int HOLD_W    = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    laser_clk_sched_if.slave bus
`ifdef LASER_CLK_SCHED_STATS_EN
    ,
    output logic [15:0]      preempt_cnt,
    output logic [15:0]      grant_cnt
`endif
);

    localparam int                GW         = $clog2(GUARD_CYC + 1);
    localparam logic [GW-1:0]     GUARD_LAST = GW'(GUARD_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_PRE   = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GUARD = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              ready_q, ready_d;
    logic              div_en_q, div_en_d;
    logic              busy_q, busy_d;
    logic [7:0]        div_value_q, div_value_d;
    logic [GW-1:0]     guard_q, guard_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              owner_q, owner_d;
    logic              rr_q, rr_d;

    logic              winner;
    logic [7:0]        win_cfg;
    logic [7:0]        norm_cfg;
    logic              own_req;
    logic              other_req;

    // rr_q names the requester that wins when both ask at once
    assign winner    = (bus.req == 2'b11) ? rr_q : bus.req[1];
    assign win_cfg   = winner ? bus.div_cfg1 : bus.div_cfg0;
    assign norm_cfg  = (win_cfg == 8'd0) ? 8'd1 : win_cfg;
    assign own_req   = bus.req[owner_q];
    assign other_req = bus.req[~owner_q];

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ready_d     = ready_q;
        div_en_d    = div_en_q;
        div_value_d = div_value_q;
        guard_d     = guard_q;
        hold_d      = hold_q;
        owner_d     = owner_q;
        rr_d        = rr_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    state_d     = S_GUARD;
                    gnt_d       = winner ? 2'b10 : 2'b01;
                    owner_d     = winner;
                    div_value_d = norm_cfg;
                    guard_d     = '0;
                    hold_d      = '0;
                    ready_d     = 1'b0;
                    div_en_d    = 1'b0;
                end
            end
            S_GUARD: begin
                if (!own_req) begin
                    state_d  = S_DRAIN;
                    gnt_d    = 2'b00;
                    ready_d  = 1'b0;
                    div_en_d = 1'b0;
                end else if (guard_q == GUARD_LAST) begin
                    state_d  = S_RUN;
                    ready_d  = 1'b1;
                    div_en_d = 1'b1;
                    hold_d   = '0;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            S_RUN: begin
                // Release takes precedence over preemption when both hold this cycle
                if (!own_req || (other_req && hold_q == HOLD_PRE)) begin
                    state_d  = S_DRAIN;
                    gnt_d    = 2'b00;
                    ready_d  = 1'b0;
                    div_en_d = 1'b0;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                rr_d    = ~owner_q;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            gnt_q       <= 2'b00;
            ready_q     <= 1'b0;
            div_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            div_value_q <= 8'd0;
            guard_q     <= '0;
            hold_q      <= '0;
            owner_q     <= 1'b0;
            rr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ready_q     <= ready_d;
            div_en_q    <= div_en_d;
            busy_q      <= busy_d;
            div_value_q <= div_value_d;
            guard_q     <= guard_d;
            hold_q      <= hold_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.ready     = ready_q;
    assign bus.div_en    = div_en_q;
    assign bus.busy      = busy_q;
    assign bus.div_value = div_value_q;

`ifdef LASER_CLK_SCHED_STATS_EN
    logic [15:0] preempt_cnt_q, preempt_cnt_d;
    logic [15:0] grant_cnt_q, grant_cnt_d;
    logic        grant_evt;
    logic        preempt_evt;

    assign grant_evt   = (state_q == S_IDLE) && (bus.req != 2'b00);
    assign preempt_evt = (state_q == S_RUN) && own_req && other_req && (hold_q == HOLD_PRE);

    always_comb begin
        grant_cnt_d   = grant_cnt_q;
        preempt_cnt_d = preempt_cnt_q;
        if (grant_evt && grant_cnt_q != 16'hFFFF)
            grant_cnt_d = grant_cnt_q + 16'd1;
        if (preempt_evt && preempt_cnt_q != 16'hFFFF)
            preempt_cnt_d = preempt_cnt_q + 16'd1;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            grant_cnt_q   <= 16'd0;
            preempt_cnt_q <= 16'd0;
        end else begin
            grant_cnt_q   <= grant_cnt_d;
            preempt_cnt_q <= preempt_cnt_d;
        end
    end

    assign grant_cnt   = grant_cnt_q;
    assign preempt_cnt = preempt_cnt_q;
`endif

    a_gnt_onehot0: assert property (@(posedge CLOCK_50) disable iff (!reset) $onehot0(gnt_q));
    a_ready_en:    assert property (@(posedge CLOCK_50) disable iff (!reset) ready_q |-> div_en_q);
    a_en_gnt:      assert property (@(posedge CLOCK_50) disable iff (!reset) div_en_q |-> (gnt_q != 2'b00));

endmodule

// File: tb/tb_laser_clk_sched.sv
// Directed bench for laser_clk_sched with GUARD_CYC=4, MAX_HOLD=8.
// Observed outputs are packed as {gnt, ready, div_en, busy, div_value}.
module tb_laser_clk_sched;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b0;
    int   n_cmp    = 0;
    int   n_err    = 0;

    laser_clk_sched_if bus_if();

`ifdef LASER_CLK_SCHED_STATS_EN
    logic [15:0] preempt_cnt;
    logic [15:0] grant_cnt;
`endif

    laser_clk_sched #(
        .GUARD_CYC (4),
        .MAX_HOLD  (8),
        .HOLD_W    (16)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus_if)
`ifdef LASER_CLK_SCHED_STATS_EN
        ,
        .preempt_cnt (preempt_cnt),
        .grant_cnt   (grant_cnt)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    logic [12:0] obs;
    logic [12:0] e;
    assign obs = {bus_if.gnt, bus_if.ready, bus_if.div_en, bus_if.busy, bus_if.div_value};

    function automatic logic [12:0] ex(input logic [1:0] g, input logic r, input logic en,
                                       input logic b, input logic [7:0] v);
        return {g, r, en, b, v};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic apply_reset();
        bus_if.req = 2'b00;
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus_if.req = 2'b00; bus_if.div_cfg0 = 8'd0; bus_if.div_cfg1 = 8'd0;
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        e = ex(2'b00, 1'b0, 1'b0, 1'b0, 8'd0); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL reset_state got=%h want=%h", obs, e); end
        step(1);
        e = ex(2'b00, 1'b0, 1'b0, 1'b0, 8'd0); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL reset_idle got=%h want=%h", obs, e); end
    endtask

    task automatic test_grant_release();
        bus_if.div_cfg0 = 8'd10; bus_if.req = 2'b01;
        step(1);
        e = ex(2'b01, 1'b0, 1'b0, 1'b1, 8'd10); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL grant_guard_entry got=%h want=%h", obs, e); end
        step(3);
        e = ex(2'b01, 1'b0, 1'b0, 1'b1, 8'd10); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL grant_guard_last got=%h want=%h", obs, e); end
        step(1);
        e = ex(2'b01, 1'b1, 1'b1, 1'b1, 8'd10); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL grant_run_entry got=%h want=%h", obs, e); end
        bus_if.req = 2'b00;
        step(1);
        e = ex(2'b00, 1'b0, 1'b0, 1'b1, 8'd10); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL release_drain got=%h want=%h", obs, e); end
        step(1);
        e = ex(2'b00, 1'b0, 1'b0, 1'b0, 8'd10); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL release_idle got=%h want=%h", obs, e); end
    endtask

    task automatic test_guard_abort();
        apply_reset();
        bus_if.div_cfg0 = 8'd3; bus_if.req = 2'b01;
        step(1);
        bus_if.req = 2'b00;
        step(1);
        e = ex(2'b00, 1'b0, 1'b0, 1'b1, 8'd3); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL guard_abort_drain got=%h want=%h", obs, e); end
        step(1);
        e = ex(2'b00, 1'b0, 1'b0, 1'b0, 8'd3); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL guard_abort_idle got=%h want=%h", obs, e); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus_if.div_cfg0 = 8'd4; bus_if.div_cfg1 = 8'd3; bus_if.req = 2'b11;
        step(1);
        e = ex(2'b01, 1'b0, 1'b0, 1'b1, 8'd4); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL tie_first_r0 got=%h want=%h", obs, e); end
        step(4);
        bus_if.req = 2'b10;
        step(3);
        e = ex(2'b10, 1'b0, 1'b0, 1'b1, 8'd3); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL tie_then_r1 got=%h want=%h", obs, e); end
        bus_if.req = 2'b11;
        step(4);
        e = ex(2'b10, 1'b1, 1'b1, 1'b1, 8'd3); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL tie_r1_run got=%h want=%h", obs, e); end
        step(10);
        e = ex(2'b01, 1'b0, 1'b0, 1'b1, 8'd4); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL alt_back_r0 got=%h want=%h", obs, e); end
        step(14);
        e = ex(2'b10, 1'b0, 1'b0, 1'b1, 8'd3); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL alt_back_r1 got=%h want=%h", obs, e); end
    endtask

    task automatic test_preempt();
        apply_reset();
        bus_if.div_cfg0 = 8'd5; bus_if.div_cfg1 = 8'd6; bus_if.req = 2'b01;
        step(5);
        bus_if.req = 2'b11;
        step(7);
        e = ex(2'b01, 1'b1, 1'b1, 1'b1, 8'd5); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL preempt_last_run got=%h want=%h", obs, e); end
        step(1);
        e = ex(2'b00, 1'b0, 1'b0, 1'b1, 8'd5); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL preempt_drain got=%h want=%h", obs, e); end
        step(1);
        e = ex(2'b00, 1'b0, 1'b0, 1'b0, 8'd5); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL preempt_idle got=%h want=%h", obs, e); end
        step(1);
        e = ex(2'b10, 1'b0, 1'b0, 1'b1, 8'd6); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL preempt_regrant got=%h want=%h", obs, e); end
`ifdef LASER_CLK_SCHED_STATS_EN
        n_cmp++;
        if (preempt_cnt !== 16'd1) begin n_err++; $display("FAIL preempt_cnt got=%0d want=1", preempt_cnt); end
        n_cmp++;
        if (grant_cnt !== 16'd2) begin n_err++; $display("FAIL grant_cnt got=%0d want=2", grant_cnt); end
`endif
    endtask

    task automatic test_uncontended();
        apply_reset();
        bus_if.div_cfg0 = 8'd2; bus_if.div_cfg1 = 8'd11; bus_if.req = 2'b01;
        step(25);
        e = ex(2'b01, 1'b1, 1'b1, 1'b1, 8'd2); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL uncontended_hold got=%h want=%h", obs, e); end
        bus_if.req = 2'b10;
        step(3);
        e = ex(2'b10, 1'b0, 1'b0, 1'b1, 8'd11); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL uncontended_switch got=%h want=%h", obs, e); end
    endtask

    task automatic test_cfg_zero();
        apply_reset();
        bus_if.div_cfg0 = 8'd0; bus_if.req = 2'b01;
        step(1);
        e = ex(2'b01, 1'b0, 1'b0, 1'b1, 8'd1); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL cfg_zero_norm got=%h want=%h", obs, e); end
        step(4);
        bus_if.div_cfg0 = 8'd20;
        step(1);
        e = ex(2'b01, 1'b1, 1'b1, 1'b1, 8'd1); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL cfg_change_ignored got=%h want=%h", obs, e); end
        bus_if.req = 2'b00;
        step(2);
        e = ex(2'b00, 1'b0, 1'b0, 1'b0, 8'd1); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL cfg_idle_hold got=%h want=%h", obs, e); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus_if.div_cfg0 = 8'd7; bus_if.req = 2'b01;
        step(1);
        #2 reset = 1'b0;
        #1;
        e = ex(2'b00, 1'b0, 1'b0, 1'b0, 8'd0); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL async_reset_guard got=%h want=%h", obs, e); end
        bus_if.req = 2'b00;
        step(1);
        reset = 1'b1;
        bus_if.req = 2'b01;
        step(5);
        e = ex(2'b01, 1'b1, 1'b1, 1'b1, 8'd7); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL async_pre_run got=%h want=%h", obs, e); end
        #2 reset = 1'b0;
        #1;
        e = ex(2'b00, 1'b0, 1'b0, 1'b0, 8'd0); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL async_reset_run got=%h want=%h", obs, e); end
        bus_if.req = 2'b00;
        step(1);
        reset = 1'b1;
        bus_if.div_cfg1 = 8'd9; bus_if.req = 2'b10;
        step(1);
        e = ex(2'b10, 1'b0, 1'b0, 1'b1, 8'd9); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL post_reset_grant got=%h want=%h", obs, e); end
        step(4);
        e = ex(2'b10, 1'b1, 1'b1, 1'b1, 8'd9); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL post_reset_run got=%h want=%h", obs, e); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before test sequence ended");
        $fatal(1);
    end

    initial begin
        bus_if.req = 2'b00; bus_if.div_cfg0 = 8'd0; bus_if.div_cfg1 = 8'd0;
        test_reset();
        test_grant_release();
        test_guard_abort();
        test_back_to_back();
        test_preempt();
        test_uncontended();
        test_cfg_zero();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
